// File: rtl/nes_pkg.sv
// Shared NES pad definitions: frame width, button indices, link state encoding.
// Used by both the pad responder and the console-side input controller.
package nes_pkg;

   localparam int NES_BITS  = 8;

   localparam int BTN_A      = 0;
   localparam int BTN_B      = 1;
   localparam int BTN_SELECT = 2;
   localparam int BTN_START  = 3;
   localparam int BTN_UP     = 4;
   localparam int BTN_DOWN   = 5;
   localparam int BTN_LEFT   = 6;
   localparam int BTN_RIGHT  = 7;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } nes_state_e;

   // 4021-style shift: LSB leaves, zero enters at the MSB
   function automatic logic [NES_BITS-1:0] shift_out(
      input logic [NES_BITS-1:0] v
   );
      return {1'b0, v[NES_BITS-1:1]};
   endfunction

endpackage

// File: rtl/nes_sync_edge.sv
// Synchronizer for an async console line, with a minimum-high filter.
// EDGE_OUT=1 gives a one-cycle rise strobe, EDGE_OUT=0 the synchronized level.
module nes_sync_edge #(
   parameter int SYNC_STAGES = 2,
   parameter int MIN_HIGH    = 1,
   parameter bit EDGE_OUT    = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic async_i,
   output logic out_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] sync_d;
   logic                   level;

   // shift the raw input through the synchronizer chain
   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], async_i};
   end

   // synchronizer flops
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign level = sync_q[SYNC_STAGES-1];

   if (EDGE_OUT) begin : g_edge
      localparam int CW = $clog2(MIN_HIGH + 1);

      logic [CW-1:0] cnt_q;
      logic [CW-1:0] cnt_d;
      logic          rise_q;
      logic          rise_d;

      // count high cycles, saturating; strobe once when the minimum is reached
      always_comb begin
         cnt_d  = cnt_q;
         rise_d = 1'b0;
         if (!level) begin
            cnt_d = '0;
         end else if (cnt_q != CW'(MIN_HIGH)) begin
            cnt_d = cnt_q + CW'(1);
         end
         rise_d = level && (cnt_q == CW'(MIN_HIGH - 1));
      end

      // filter counter and strobe register
      always_ff @(posedge clk) begin
         if (reset) begin
            cnt_q  <= '0;
            rise_q <= 1'b0;
         end else begin
            cnt_q  <= cnt_d;
            rise_q <= rise_d;
         end
      end

      assign out_o = rise_q;
   end else begin : g_level
      assign out_o = level;
   end

endmodule

// File: rtl/nes_pad_responder.sv
// NES pad emulator: captures buttons on latch, shifts them out per pulse.
// nes_data is active-low and idles high once the frame is exhausted.
module nes_pad_responder
   import nes_pkg::*;
#(
   parameter int SYNC_STAGES      = 2,
   parameter int PULSE_MIN_CYCLES = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NES_BITS-1:0] buttons,
   input  logic                nes_latch,
   input  logic                nes_pulse,
   output logic                nes_data,
   output logic                frame_done,
   output logic [3:0]          bit_index
);

   logic latch_s;
   logic pulse_rise;

   nes_state_e          state_q, state_d;
   logic [NES_BITS-1:0] shreg_q, shreg_d;
   logic [3:0]          bit_q, bit_d;
   logic                data_q, data_d;
   logic                done_q, done_d;

   nes_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .MIN_HIGH    (1),
      .EDGE_OUT    (1'b0)
   ) u_latch_sync (
      .clk     (clk),
      .reset   (reset),
      .async_i (nes_latch),
      .out_o   (latch_s)
   );

   nes_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES),
      .MIN_HIGH    (PULSE_MIN_CYCLES),
      .EDGE_OUT    (1'b1)
   ) u_pulse_sync (
      .clk     (clk),
      .reset   (reset),
      .async_i (nes_pulse),
      .out_o   (pulse_rise)
   );

   // next state: latch level overrides everything, else per-state shifting
   always_comb begin
      state_d = state_q;
      shreg_d = shreg_q;
      bit_d   = bit_q;
      data_d  = data_q;
      done_d  = 1'b0;
      if (latch_s) begin
         state_d = LOAD;
         shreg_d = buttons;
         bit_d   = 4'd0;
         data_d  = ~buttons[BTN_A];
      end else begin
         unique case (state_q)
            IDLE: begin
               if (pulse_rise) begin
                  shreg_d = shift_out(shreg_q);
                  data_d  = ~shreg_q[1];
               end
            end
            LOAD: begin
               state_d = SHIFT;
            end
            SHIFT: begin
               if (pulse_rise) begin
                  shreg_d = shift_out(shreg_q);
                  data_d  = ~shreg_q[1];
                  bit_d   = bit_q + 4'd1;
                  if (bit_q == 4'(NES_BITS - 1)) begin
                     done_d  = 1'b1;
                     state_d = DONE;
                  end
               end
            end
            DONE: begin
               data_d = 1'b1;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // state, shift register and output registers
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         shreg_q <= '0;
         bit_q   <= 4'd0;
         data_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         shreg_q <= shreg_d;
         bit_q   <= bit_d;
         data_q  <= data_d;
         done_q  <= done_d;
      end
   end

   assign nes_data   = data_q;
   assign frame_done = done_q;
   assign bit_index  = bit_q;

endmodule
